// File: rtl/scara_pkg.sv
// Shared types for the SCARA command scheduler: queued command layout, scheduler states,
// and control-word bit positions.
package scara_pkg;

    localparam int CTRL_MOVE = 0;
    localparam int CTRL_REL  = 2;
    localparam int CTRL_PEN  = 3;
    localparam int CTRL_TOOL = 4;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [13:0] x;
        logic [13:0] y;
        logic        pen;
    } scara_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } sched_state_t;

endpackage

// File: rtl/scara_cmd_fifo.sv
// Synchronous command FIFO with registered count; flush empties it on the next edge and
// beats a simultaneous push. Pushes when full and pops when empty are ignored.
module scara_cmd_fifo
    import scara_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  scara_cmd_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output scara_cmd_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    scara_cmd_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the arithmetic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/scara_cmd_scheduler.sv
// Queues host commands and issues them one at a time to the motion controller with a watchdog.
// Optional SCARA_SCHED_STATS_EN adds done_count / fault_count statistics outputs.
module scara_cmd_scheduler
    import scara_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int TO_W           = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [4:0]             cmd_ctrl,
    input  logic [13:0]            cmd_x,
    input  logic [13:0]            cmd_y,
    input  logic                   cmd_pen,
    input  logic                   flush,
    input  logic                   fault_clear,
    input  logic                   ctrl_ready,
    output logic                   ctrl_enable,
    output logic [4:0]             ctrl_state_reg,
    output logic [13:0]            ctrl_x,
    output logic [13:0]            ctrl_y,
    output logic                   ctrl_pen,
    output logic                   busy,
    output logic                   fault,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef SCARA_SCHED_STATS_EN
    ,
    output logic [15:0]            done_count,
    output logic [7:0]             fault_count
`endif
);

    sched_state_t    state;
    sched_state_t    state_nxt;
    scara_cmd_t      head;
    scara_cmd_t      push_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            issue;
    logic            wd_expired;
    logic            head_live;
    logic [TO_W-1:0] wd;

    assign push_data = '{ctrl: cmd_ctrl, x: cmd_x, y: cmd_y, pen: cmd_pen};
    assign cmd_ready = !fifo_full;

    scara_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wd_expired = ((state == ISSUE) || (state == DRAIN)) &&
                        (wd == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!fifo_empty && ctrl_ready) state_nxt = ISSUE;
            ISSUE: if (wd_expired)                state_nxt = FAULT;
                   else if (!ctrl_ready)          state_nxt = DRAIN;
            DRAIN: if (wd_expired)                state_nxt = FAULT;
                   else if (ctrl_ready)           state_nxt = IDLE;
            FAULT: if (fault_clear)               state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ctrl_enable = (state == ISSUE);
        fault       = (state == FAULT);
        busy        = (state != IDLE) || !fifo_empty;
    end

    assign issue = (state == IDLE) && (state_nxt == ISSUE);
    // The issued command leaves the queue when ISSUE ends, unless a flush already removed it.
    assign pop   = (state == ISSUE) && (state_nxt != ISSUE) && head_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_state_reg <= '0;
            ctrl_x         <= '0;
            ctrl_y         <= '0;
            ctrl_pen       <= 1'b0;
            wd             <= '0;
            head_live      <= 1'b0;
        end else begin
            if (issue) begin
                ctrl_state_reg <= head.ctrl;
                ctrl_x         <= head.x;
                ctrl_y         <= head.y;
                ctrl_pen       <= head.pen;
                head_live      <= 1'b1;
            end
            if (pop || flush) head_live <= 1'b0;
            if (issue)                                   wd <= '0;
            else if ((state == ISSUE) || (state == DRAIN)) wd <= wd + 1'b1;
        end
    end

`ifdef SCARA_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            done_count  <= '0;
            fault_count <= '0;
        end else begin
            if ((state == DRAIN) && (state_nxt == IDLE)) done_count <= done_count + 1'b1;
            if ((state != FAULT) && (state_nxt == FAULT) && (fault_count != 8'hFF))
                fault_count <= fault_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_scara_cmd_scheduler.sv
// Randomized and directed bench for scara_cmd_scheduler against a queue-based reference model.
module tb_scara_cmd_scheduler;
    localparam int DEPTH = 8;
    localparam int TO    = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_pen, flush, fault_clear, ctrl_ready;
    logic [4:0]  cmd_ctrl;
    logic [13:0] cmd_x, cmd_y;
    logic        cmd_ready, ctrl_enable, ctrl_pen, busy, fault;
    logic [4:0]  ctrl_state_reg;
    logic [13:0] ctrl_x, ctrl_y;
    logic [CW-1:0] fifo_count;
`ifdef SCARA_SCHED_STATS_EN
    logic [15:0] done_count;
    logic [7:0]  fault_count;
`endif

    always #5 clk = ~clk;

    scara_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .TO_W(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ctrl(cmd_ctrl), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_pen(cmd_pen),
        .flush(flush), .fault_clear(fault_clear), .ctrl_ready(ctrl_ready),
        .ctrl_enable(ctrl_enable), .ctrl_state_reg(ctrl_state_reg), .ctrl_x(ctrl_x),
        .ctrl_y(ctrl_y), .ctrl_pen(ctrl_pen), .busy(busy), .fault(fault),
        .fifo_count(fifo_count)
`ifdef SCARA_SCHED_STATS_EN
        , .done_count(done_count), .fault_count(fault_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0=waiting, 1=offered to controller, 2=controller working, 3=faulted.
    logic [33:0] mq[$];
    logic [33:0] cur;
    int          phase, wd;
    bit          cur_in_q;
    logic [15:0] m_done;
    logic [7:0]  m_faults;

    task automatic model_update();
        logic [33:0] din;
        bit accept, drop;
        int nphase;
        din = {cmd_ctrl, cmd_x, cmd_y, cmd_pen};
        if (reset) begin
            mq.delete(); cur = '0; phase = 0; wd = 0; cur_in_q = 0; m_done = '0; m_faults = '0;
            return;
        end
        accept = cmd_valid && (mq.size() < DEPTH);
        drop   = 0;
        nphase = phase;
        case (phase)
            0: if (mq.size() > 0 && ctrl_ready) begin
                   nphase = 1; cur = mq[0]; wd = 0; cur_in_q = 1;
               end
            1: begin
                   if (wd == TO - 1) nphase = 3;
                   else if (!ctrl_ready) nphase = 2;
                   if (nphase != 1 && cur_in_q) begin drop = 1; cur_in_q = 0; end
                   wd++;
               end
            2: begin
                   if (wd == TO - 1) nphase = 3;
                   else if (ctrl_ready) begin nphase = 0; m_done++; end
                   wd++;
               end
            default: if (fault_clear) nphase = 0;
        endcase
        if (nphase == 3 && phase != 3 && m_faults != 8'hFF) m_faults++;
        if (flush) begin
            mq.delete(); cur_in_q = 0;
        end else begin
            if (drop) void'(mq.pop_front());
            if (accept) mq.push_back(din);
        end
        phase = nphase;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("ctrl_enable", 32'(ctrl_enable), 32'(phase == 1));
        check("fault", 32'(fault), 32'(phase == 3));
        check("busy", 32'(busy), 32'(phase != 0 || mq.size() != 0));
        check("ctrl_state_reg", 32'(ctrl_state_reg), 32'(cur[33:29]));
        check("ctrl_x", 32'(ctrl_x), 32'(cur[28:15]));
        check("ctrl_y", 32'(ctrl_y), 32'(cur[14:1]));
        check("ctrl_pen", 32'(ctrl_pen), 32'(cur[0]));
`ifdef SCARA_SCHED_STATS_EN
        check("done_count", 32'(done_count), 32'(m_done));
        check("fault_count", 32'(fault_count), 32'(m_faults));
`endif
    endtask

    task automatic rand_cmd();
        cmd_ctrl = 5'($urandom); cmd_x = 14'($urandom); cmd_y = 14'($urandom);
        cmd_pen = 1'($urandom);
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd_ctrl = '0; cmd_x = '0; cmd_y = '0; cmd_pen = 0;
        flush = 0; fault_clear = 0; ctrl_ready = 0;
        step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        reset = 0;
        step();

        // Single move: enable rises one edge after the push edge.
        ctrl_ready = 1; cmd_valid = 1; cmd_ctrl = 5'b00001; cmd_x = 14'd100;
        cmd_y = 14'h3FCE; cmd_pen = 0;  // y = -50
        step();
        cmd_valid = 0;
        check("lat_pre_en", 32'(ctrl_enable), 32'd0);
        step();
        check("lat_en", 32'(ctrl_enable), 32'd1);
        check("move_x", 32'(ctrl_x), 32'd100);
        check("move_y", 32'(ctrl_y), 32'h3FCE);
        ctrl_ready = 0;
        step();
        check("move_en_low", 32'(ctrl_enable), 32'd0);
        check("move_count0", 32'(fifo_count), 32'd0);
        ctrl_ready = 1;
        step();
`ifdef SCARA_SCHED_STATS_EN
        check("move_done", 32'(done_count), 32'd1);
`endif
        step();

        // Fill: nine offered with the controller stalled, eight accepted.
        ctrl_ready = 0;
        for (int i = 0; i < 9; i++) begin cmd_valid = 1; rand_cmd(); step(); end
        cmd_valid = 0;
        check("fill_count", 32'(fifo_count), 32'd8);
        check("fill_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ctrl_ready = 1; step(); step(); ctrl_ready = 0; step();
        end
        check("drain5_count", 32'(fifo_count), 32'd3);
        ctrl_ready = 1; step(); step();
        ctrl_ready = 0; cmd_valid = 1; rand_cmd(); step();
        cmd_valid = 0;
        check("pushpop_count", 32'(fifo_count), 32'd3);
        for (int i = 0; i < 40; i++) begin ctrl_ready = (i % 3) != 2; step(); end
        ctrl_ready = 1;
        for (int i = 0; i < 4; i++) step();

        // Watchdog: controller takes the command and never reports done.
        cmd_valid = 1; rand_cmd(); step();
        cmd_valid = 0; step();
        ctrl_ready = 0;
        for (int i = 0; i < TO - 1; i++) step();
        check("wd_no_fault", 32'(fault), 32'd0);
        step();
        check("wd_fault", 32'(fault), 32'd1);
        cmd_valid = 1; rand_cmd(); ctrl_ready = 1; step();
        cmd_valid = 0; fault_clear = 1; step();
        fault_clear = 0; step();
        check("post_fault_issue", 32'(ctrl_enable), 32'd1);

        // Flush while the controller is working, four commands queued.
        ctrl_ready = 0; step();
        for (int i = 0; i < 4; i++) begin cmd_valid = 1; rand_cmd(); step(); end
        cmd_valid = 0;
        check("pre_flush_count", 32'(fifo_count), 32'd4);
        flush = 1; cmd_valid = 1; rand_cmd(); step();
        flush = 0; cmd_valid = 0;
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        ctrl_ready = 1; step();
        check("flush_idle", 32'(busy), 32'd0);

        // Reset while a command is being offered.
        cmd_valid = 1; rand_cmd(); step();
        cmd_valid = 1; rand_cmd(); step();
        cmd_valid = 0;
        check("pre_rst_en", 32'(ctrl_enable), 32'd1);
        reset = 1; step();
        reset = 0;
        check("rst_en", 32'(ctrl_enable), 32'd0);
        check("rst_fifo", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid   = ($urandom_range(0, 2) != 0);
            rand_cmd();
            if ($urandom_range(0, 3) == 0) ctrl_ready = ~ctrl_ready;
            flush       = ($urandom_range(0, 63) == 0);
            fault_clear = ($urandom_range(0, 7) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 0; flush = 0; fault_clear = 0; cmd_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
